// File: rtl/inertial_pkg.sv
// Shared types and SPI command words for the inertial sensor interface.
// Read commands carry the read flag in bit 15 and address in [14:8].
package inertial_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH
    } imu_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_BACKPORCH
    } spi_state_t;

    localparam logic [15:0] CMD_INIT1 = 16'h0D02;
    localparam logic [15:0] CMD_INIT2 = 16'h1053;
    localparam logic [15:0] CMD_INIT3 = 16'h1150;
    localparam logic [15:0] CMD_INIT4 = 16'h1460;

    localparam logic [15:0] CMD_RD_PL = 16'hA200;
    localparam logic [15:0] CMD_RD_PH = 16'hA300;
    localparam logic [15:0] CMD_RD_AL = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH = 16'hAD00;

endpackage

// File: rtl/inertial_intf_spi.sv
// 16-bit SPI master, mode 3: MOSI changes on SCLK fall, MISO sampled on rise.
// One shift register serves both directions; done pulses 1 clk after SS_n rises.
module spi_mstr16
    import inertial_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [SCLK_DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [SCLK_DIV_W-1:0] DIV_HALF = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_LAST = '1;

    spi_state_t            state;
    logic [SCLK_DIV_W-1:0] div;
    logic [3:0]            bit_cnt;
    logic [15:0]           shft;
    logic                  miso_smpl;
    logic                  ss_rise;
    logic                  sclk_fall;
    logic                  sclk_rise;

    assign SCLK      = ~div[SCLK_DIV_W-1];
    assign MOSI      = shft[15];
    assign rd_data   = shft;
    assign sclk_fall = (div == DIV_HALF);
    assign sclk_rise = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SPI_IDLE;
            div       <= '0;
            bit_cnt   <= '0;
            shft      <= '0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            ss_rise   <= 1'b0;
            done      <= 1'b0;
        end else begin
            ss_rise <= 1'b0;
            done    <= ss_rise;
            unique case (state)
                SPI_IDLE: begin
                    if (wrt) begin
                        shft    <= cmd;
                        div     <= '0;
                        bit_cnt <= '0;
                        SS_n    <= 1'b0;
                        state   <= SPI_SHIFT;
                    end
                end
                SPI_SHIFT: begin
                    div <= div + DIV_ONE;
                    // MSB is already on MOSI, so the first fall does not shift
                    if (sclk_fall && bit_cnt != 4'd0)
                        shft <= {shft[14:0], miso_smpl};
                    if (sclk_rise) begin
                        miso_smpl <= MISO;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15)
                            state <= SPI_BACKPORCH;
                    end
                end
                SPI_BACKPORCH: begin
                    div <= div + DIV_ONE;
                    if (sclk_fall) begin
                        shft    <= {shft[14:0], miso_smpl};
                        div     <= '0;
                        SS_n    <= 1'b1;
                        ss_rise <= 1'b1;
                        state   <= SPI_IDLE;
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/inertial_intf.sv
// IMU producer: powers up the sensor over SPI, then reads pitch rate and
// Z accel on every data-ready and presents them with a one-cycle vld.
module inertial_intf
    import inertial_pkg::*;
#(
    parameter int INIT_WAIT_W = 16,
    parameter int SCLK_DIV_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam logic [INIT_WAIT_W-1:0] T_ONE = 1;

    imu_state_t             state;
    logic [INIT_WAIT_W-1:0] timer;
    logic                   int_ff1;
    logic                   int_sync;
    logic                   wrt;
    logic [15:0]            cmd;
    logic                   done;
    logic [7:0]             rd_lo;
    logic [7:0]             rd_hi_unused;
    logic [7:0]             pl;
    logic [7:0]             ph;
    logic [7:0]             al;

    spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data ({rd_hi_unused, rd_lo}),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_ff1  <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_ff1  <= INT;
            int_sync <= int_ff1;
        end
    end

    // Saturates at all-ones, which releases the init sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (state == INIT_WAIT && !(&timer))
            timer <= timer + T_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT_WAIT;
            wrt     <= 1'b0;
            cmd     <= '0;
            pl      <= '0;
            ph      <= '0;
            al      <= '0;
            ptch_rt <= '0;
            AZ      <= '0;
            vld     <= 1'b0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            unique case (state)
                INIT_WAIT: if (&timer) begin
                    wrt   <= 1'b1;
                    cmd   <= CMD_INIT1;
                    state <= INIT1;
                end
                INIT1: if (done) begin
                    wrt   <= 1'b1;
                    cmd   <= CMD_INIT2;
                    state <= INIT2;
                end
                INIT2: if (done) begin
                    wrt   <= 1'b1;
                    cmd   <= CMD_INIT3;
                    state <= INIT3;
                end
                INIT3: if (done) begin
                    wrt   <= 1'b1;
                    cmd   <= CMD_INIT4;
                    state <= INIT4;
                end
                INIT4: if (done)
                    state <= WAIT_INT;
                WAIT_INT: if (int_sync) begin
                    wrt   <= 1'b1;
                    cmd   <= CMD_RD_PL;
                    state <= RD_PL;
                end
                RD_PL: if (done) begin
                    pl    <= rd_lo;
                    wrt   <= 1'b1;
                    cmd   <= CMD_RD_PH;
                    state <= RD_PH;
                end
                RD_PH: if (done) begin
                    ph    <= rd_lo;
                    wrt   <= 1'b1;
                    cmd   <= CMD_RD_AL;
                    state <= RD_AL;
                end
                RD_AL: if (done) begin
                    al    <= rd_lo;
                    wrt   <= 1'b1;
                    cmd   <= CMD_RD_AH;
                    state <= RD_AH;
                end
                // Final high byte goes straight to the output register
                RD_AH: if (done) begin
                    ptch_rt <= {ph, pl};
                    AZ      <= {rd_lo, al};
                    vld     <= 1'b1;
                    state   <= WAIT_INT;
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_inertial_intf.sv
// Directed bench for inertial_intf with a behavioural SPI sensor model.
// Power-up timer shortened to 10 bits to keep the run short.
module tb_inertial_intf;

    localparam int IW = 10;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        INT  = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    int errors = 0;
    int checks = 0;
    int vld_cnt = 0;

    logic [15:0] frames[$];
    logic [7:0]  regs[0:127];
    int          bit_i = 0;
    logic [15:0] rx = '0;
    logic [6:0]  addr = '0;
    logic [7:0]  d;
    logic        sclk_q = 1'b1;

    inertial_intf #(.INIT_WAIT_W(IW), .SCLK_DIV_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (INT),
        .MISO    (MISO),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ)
    );

    always #5 clk = ~clk;

    // Sensor model: clocked on the system clock, reacts to SCLK edges
    always @(posedge clk) begin
        if (SS_n !== 1'b0) begin
            bit_i = 0;
            MISO  = 1'b0;
        end else begin
            if (SCLK && !sclk_q) begin
                rx    = {rx[14:0], MOSI};
                bit_i = bit_i + 1;
                if (bit_i == 8)
                    addr = rx[6:0];
                if (bit_i == 16)
                    frames.push_back(rx);
            end
            if (!SCLK && sclk_q && bit_i >= 8 && bit_i < 16) begin
                d    = regs[addr];
                MISO = d[15-bit_i];
            end
        end
        sclk_q = SCLK;
    end

    always @(posedge clk)
        if (vld === 1'b1)
            vld_cnt = vld_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n, input int lim);
        int k = 0;
        while (frames.size() < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("frame_wait", 32'(frames.size() >= n), 1);
    endtask

    task automatic wait_vld(input int lim);
        int k = 0;
        while (vld !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("vld_wait", 32'(vld), 1);
    endtask

    task automatic wait_ssn(input logic lvl, input int lim);
        int k = 0;
        while (SS_n !== lvl && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("ssn_wait", 32'(SS_n), 32'(lvl));
    endtask

    task automatic ss_hold(output int n);
        n = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (SS_n !== 1'b1) break;
            n++;
        end
    endtask

    task automatic chk_init(input int b);
        chk("init1", 32'(frames[b]),   32'h0D02);
        chk("init2", 32'(frames[b+1]), 32'h1053);
        chk("init3", 32'(frames[b+2]), 32'h1150);
        chk("init4", 32'(frames[b+3]), 32'h1460);
    endtask

    initial begin
        int n;
        int base;
        int vc0;

        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        regs[7'h22] = 8'h34;
        regs[7'h23] = 8'h12;
        regs[7'h2C] = 8'h78;
        regs[7'h2D] = 8'h56;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vld",  32'(vld),     0);
        chk("rst_ptch", 32'(ptch_rt), 0);
        chk("rst_az",   32'(AZ),      0);
        chk("rst_ssn",  32'(SS_n),    1);
        chk("rst_sclk", 32'(SCLK),    1);
        chk("rst_mosi", 32'(MOSI),    0);
        rst = 1'b0;

        // Power-up wait then the four config frames
        ss_hold(n);
        chk("pwr_wait", 32'(n >= 1023 && n <= 1026), 1);
        wait_frames(4, 4000);
        chk_init(0);
        repeat (1500) @(negedge clk);
        chk("idle_frames", 32'(frames.size()), 4);
        chk("idle_ssn",    32'(SS_n),          1);
        chk("idle_vld",    32'(vld_cnt),       0);

        // Single INT pulse -> one sample
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        wait_vld(3000);
        chk("s1_ptch", 32'(ptch_rt), 32'h1234);
        chk("s1_az",   32'(AZ),      32'h5678);
        chk("s1_pl",   32'(frames[4]), 32'hA200);
        chk("s1_ph",   32'(frames[5]), 32'hA300);
        chk("s1_al",   32'(frames[6]), 32'hAC00);
        chk("s1_ah",   32'(frames[7]), 32'hAD00);
        @(negedge clk);
        chk("s1_vld_width", 32'(vld),     0);
        chk("s1_vld_cnt",   32'(vld_cnt), 1);
        repeat (200) @(negedge clk);
        chk("s1_hold_ptch", 32'(ptch_rt),       32'h1234);
        chk("s1_hold_nfr",  32'(frames.size()), 8);

        // INT held high: back-to-back samples, extreme values
        INT = 1'b1;
        wait_vld(3000);
        chk("s2_ptch", 32'(ptch_rt), 32'h1234);
        chk("s2_az",   32'(AZ),      32'h5678);
        regs[7'h22] = 8'hFF;
        regs[7'h23] = 8'h7F;
        regs[7'h2C] = 8'h00;
        regs[7'h2D] = 8'h80;
        @(negedge clk);
        wait_vld(3000);
        chk("s3_ptch", 32'(ptch_rt), 32'h7FFF);
        chk("s3_az",   32'(AZ),      32'h8000);
        @(negedge clk);
        chk("s3_vld_cnt", 32'(vld_cnt), 3);

        // Third read in progress: reset during RD_PH
        base = frames.size();
        wait_frames(base + 1, 1000);
        chk("s4_pl", 32'(frames[base]), 32'hA200);
        wait_ssn(1'b1, 100);
        wait_ssn(1'b0, 100);
        repeat (100) @(negedge clk);
        chk("mid_ssn_low", 32'(SS_n), 0);
        vc0 = vld_cnt;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ssn",  32'(SS_n),    1);
        chk("mid_rst_vld",  32'(vld),     0);
        chk("mid_rst_ptch", 32'(ptch_rt), 0);
        chk("mid_rst_az",   32'(AZ),      0);
        regs[7'h22] = 8'hCD;
        regs[7'h23] = 8'hAB;
        regs[7'h2C] = 8'h01;
        regs[7'h2D] = 8'hEF;
        repeat (5) @(negedge clk);
        chk("mid_rst_nfr", 32'(frames.size()), 32'(base + 1));
        chk("mid_rst_nvld", 32'(vld_cnt), 32'(vc0));

        // Re-init with INT already high: reads wait for init to finish
        base = frames.size();
        rst = 1'b0;
        ss_hold(n);
        chk("re_pwr_wait", 32'(n >= 1023 && n <= 1026), 1);
        wait_frames(base + 5, 8000);
        chk_init(base);
        chk("re_first_rd", 32'(frames[base+4]), 32'hA200);
        chk("re_no_vld",   32'(vld_cnt),        32'(vc0));
        wait_vld(3000);
        chk("re_ptch", 32'(ptch_rt), 32'hABCD);
        chk("re_az",   32'(AZ),      32'hEF01);
        INT = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
